// File: rtl/cache_def_pipe_data.sv
// ---------------------------------------------------------------------------
// cache_def_pipe_data
// Shared definitions for the cache datapath elastic pipeline register.
//   state_t         : occupancy state of the skid-buffered stage
//   PIPE_SKID_DEPTH : number of entries a skid-buffered stage can hold
//   occ_of_state    : maps a state to its entry count
// ---------------------------------------------------------------------------
package cache_def_pipe_data;

  localparam int unsigned PIPE_SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [1:0] occ_of_state(input state_t s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cache_pipe_data_bank.sv
// ---------------------------------------------------------------------------
// cache_pipe_data_bank
// Payload storage for the elastic pipeline register: a main register that
// always drives the stage output and a skid register that catches the beat
// accepted while the main register is still waiting to be drained.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   load_main       : update main this cycle
//   main_from_skid  : when loading main, take the skid entry instead of in_data
//   load_skid       : capture in_data into skid this cycle
//   in_data         : upstream payload
//   main_data       : current main register contents
// ---------------------------------------------------------------------------
module cache_pipe_data_bank #(
  parameter int unsigned       WIDTH      = 64,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_main,
  input  logic             main_from_skid,
  input  logic             load_skid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] main_data
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (load_main) begin
      main_d = main_from_skid ? skid_q : in_data;
    end
    if (load_skid) begin
      skid_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= RESET_DATA;
      skid_q <= RESET_DATA;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign main_data = main_q;

endmodule

// File: rtl/cache_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// cache_pipe_skid_reg
// Elastic valid/ready pipeline register between cache datapath stages, with
// synchronous flush. SKID=1 holds up to two entries and drives in_ready from
// a flop so out_ready never reaches in_ready combinationally; SKID=0 is a
// single register with a combinational in_ready.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   flush                : synchronous kill of all held entries
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data oldest payload
//   occupancy            : entries currently held (0..2)
// ---------------------------------------------------------------------------
module cache_pipe_skid_reg
  import cache_def_pipe_data::*;
#(
  parameter int unsigned       WIDTH      = 64,
  parameter int                SKID       = 1,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic accept;
  logic drain;
  logic load_main;
  logic main_from_skid;
  logic load_skid;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  cache_pipe_data_bank #(
    .WIDTH      (WIDTH),
    .RESET_DATA (RESET_DATA)
  ) u_bank (
    .clk            (clk),
    .reset          (reset),
    .load_main      (load_main),
    .main_from_skid (main_from_skid),
    .load_skid      (load_skid),
    .in_data        (in_data),
    .main_data      (out_data)
  );

  // Holding rule: a presented beat must not change until it is taken.
  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> $stable(out_data));

  if (SKID != 0) begin : g_skid
    state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    // Flush overrides everything; data loads are suppressed so the bank keeps
    // its contents and the discarded beat never lands anywhere.
    always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d        = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (flush) begin
        state_d        = EMPTY;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
      end
    end

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = occ_of_state(state_q);

    a_no_accept_full: assert property (@(posedge clk) disable iff (reset)
      !(state_q == FULL && accept));
    a_occ_max: assert property (@(posedge clk) disable iff (reset)
      occupancy <= 2'(PIPE_SKID_DEPTH));
  end else begin : g_noskid
    logic valid_q, valid_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    // An accept alongside a drain simply overwrites main with the new beat.
    always_comb begin
      valid_d        = valid_q;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (accept) begin
        valid_d   = 1'b1;
        load_main = 1'b1;
      end else if (drain) begin
        valid_d = 1'b0;
      end
      if (flush) begin
        valid_d   = 1'b0;
        load_main = 1'b0;
      end
    end

    assign in_ready  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign occupancy = {1'b0, valid_q};

    a_occ_max: assert property (@(posedge clk) disable iff (reset)
      occupancy <= 2'd1);
  end

endmodule

// File: tb/tb_cache_pipe_skid_reg.sv
// Testbench: instance 0 is SKID=1, instance 1 is SKID=0, both WIDTH=128.
module tb_cache_pipe_skid_reg;

  localparam int W = 128;
  localparam logic [W-1:0] RD = 128'hC0DE_0000_FACE_0000_5A5A_0000_0BAD_F00D;
  localparam int BEATS  = 10000;
  localparam int BUDGET = 60000;

  logic clk;
  logic reset;
  logic flush[2];
  logic in_valid[2];
  logic in_ready[2];
  logic out_valid[2];
  logic out_ready[2];
  logic [W-1:0] in_data[2];
  logic [W-1:0] out_data[2];
  logic [1:0] occupancy[2];

  int tests_run;
  int tests_failed;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      cache_pipe_skid_reg #(
        .WIDTH      (W),
        .SKID       ((g == 0) ? 1 : 0),
        .RESET_DATA (RD)
      ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush[g]),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_data   (in_data[g]),
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
        .out_data  (out_data[g]),
        .occupancy (occupancy[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         fl;
    logic         iv;
    logic [W-1:0] din;
    logic         ordy;
    logic         exp_ir;
    logic         exp_ov;
    logic [1:0]   exp_occ;
    logic [W-1:0] exp_dat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [W-1:0] din,
                              input logic ordy, input logic ir, input logic ov,
                              input logic [1:0] occ, input logic [W-1:0] dat);
    vec_t v;
    v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_occ = occ; v.exp_dat = dat;
    return v;
  endfunction

  task automatic applyStimulus(input int d, input logic fl, input logic iv,
                               input logic [W-1:0] din, input logic ordy);
    flush[d]     = fl;
    in_valid[d]  = iv;
    in_data[d]   = din;
    out_ready[d] = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per instance an ordered list of held beats (max 2).
  logic [W-1:0] mdl[2][2];
  int cnt[2];
  int beats[2];
  logic [31:0] seq[2];
  int cycles;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 1'b0, 1'b0, '0, 1'b0);
      cnt[d] = 0;
      beats[d] = 0;
      seq[d] = 32'd0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset%0d out_valid", d), out_valid[d], 1'b0);
      checkOutput($sformatf("reset%0d occupancy", d), occupancy[d], 2'd0);
      checkOutput($sformatf("reset%0d in_ready", d), in_ready[d], 1'b1);
      checkOutput($sformatf("reset%0d out_data", d), out_data[d], RD);
    end
    reset = 1'b0;

    // fl iv din ordy | in_ready(before edge) out_valid occ data(after edge)
    vecs.push_back(mk(0, 1, 'h11, 1, 1, 1, 1, 'h11));
    vecs.push_back(mk(0, 1, 'h22, 1, 1, 1, 1, 'h22));
    vecs.push_back(mk(0, 1, 'h33, 1, 1, 1, 1, 'h33));
    vecs.push_back(mk(0, 0, 'h00, 1, 1, 0, 0, 'h00));
    vecs.push_back(mk(0, 1, 'h0A, 0, 1, 1, 1, 'h0A));
    vecs.push_back(mk(0, 1, 'h0B, 0, 1, 1, 2, 'h0A));
    vecs.push_back(mk(0, 1, 'h0C, 0, 0, 1, 2, 'h0A));
    vecs.push_back(mk(0, 1, 'h0C, 1, 0, 1, 1, 'h0B));
    vecs.push_back(mk(0, 1, 'h0C, 1, 1, 1, 1, 'h0C));
    vecs.push_back(mk(0, 0, 'h00, 1, 1, 0, 0, 'h00));
    vecs.push_back(mk(0, 1, 'h01, 0, 1, 1, 1, 'h01));
    vecs.push_back(mk(0, 1, 'h02, 0, 1, 1, 2, 'h01));
    vecs.push_back(mk(1, 1, 'h0D, 0, 0, 0, 0, 'h00));
    vecs.push_back(mk(0, 0, 'h00, 1, 1, 0, 0, 'h00));
    vecs.push_back(mk(0, 1, 'h44, 0, 1, 1, 1, 'h44));
    vecs.push_back(mk(1, 1, 'h55, 0, 1, 0, 0, 'h00));
    vecs.push_back(mk(0, 0, 'h00, 1, 1, 0, 0, 'h00));
    vecs.push_back(mk(0, 1, 'h66, 0, 1, 1, 1, 'h66));
    vecs.push_back(mk(1, 0, 'h00, 1, 1, 0, 0, 'h00));

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].fl, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), in_ready[0], vecs[i].exp_ir);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d out_valid", i), out_valid[0], vecs[i].exp_ov);
      checkOutput($sformatf("vec%0d occupancy", i), occupancy[0], vecs[i].exp_occ);
      if (vecs[i].exp_ov) begin
        checkOutput($sformatf("vec%0d out_data", i), out_data[0], vecs[i].exp_dat);
      end
    end
    applyStimulus(0, 1'b0, 1'b0, '0, 1'b0);

    // SKID=0: fill, stall, then replace in the same cycle as the drain.
    applyStimulus(1, 1'b0, 1'b1, 'h3, 1'b0);
    #1; checkOutput("nsk empty in_ready", in_ready[1], 1'b1);
    @(posedge clk); #1;
    checkOutput("nsk first out_data", out_data[1], 'h3);
    checkOutput("nsk first occupancy", occupancy[1], 2'd1);
    applyStimulus(1, 1'b0, 1'b1, 'h4, 1'b0);
    #1; checkOutput("nsk stall in_ready", in_ready[1], 1'b0);
    @(posedge clk); #1;
    checkOutput("nsk stall out_data", out_data[1], 'h3);
    applyStimulus(1, 1'b0, 1'b1, 'h5, 1'b1);
    #1; checkOutput("nsk comb in_ready", in_ready[1], 1'b1);
    @(posedge clk); #1;
    checkOutput("nsk replace out_data", out_data[1], 'h5);
    checkOutput("nsk replace occupancy", occupancy[1], 2'd1);
    applyStimulus(1, 1'b1, 1'b1, 'h6, 1'b1);
    #1; checkOutput("nsk flush in_ready", in_ready[1], 1'b1);
    @(posedge clk); #1;
    checkOutput("nsk flush out_valid", out_valid[1], 1'b0);
    checkOutput("nsk flush occupancy", occupancy[1], 2'd0);

    // Asynchronous reset in the middle of a cycle while the skid stage is full.
    applyStimulus(0, 1'b0, 1'b1, 'h77, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 'h99, 1'b0);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 1'b1, 'h88, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    checkOutput("pre-reset occupancy", occupancy[0], 2'd2);
    applyStimulus(0, 1'b0, 1'b1, 'hAA, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset out_valid", out_valid[0], 1'b0);
    checkOutput("async reset occupancy", occupancy[0], 2'd0);
    checkOutput("async reset out_data", out_data[0], RD);
    checkOutput("async reset in_ready", in_ready[0], 1'b1);
    checkOutput("async reset nsk out_valid", out_valid[1], 1'b0);
    checkOutput("async reset nsk out_data", out_data[1], RD);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, '0, 1'b0);
    reset = 1'b0;

    // Random traffic on both instances against the ordered-list model.
    cycles = 0;
    while ((beats[0] < BEATS || beats[1] < BEATS) && cycles < BUDGET) begin
      for (int d = 0; d < 2; d++) begin
        applyStimulus(d, ($urandom_range(63) == 0), 1'($urandom_range(1)),
                      {seq[d], $urandom, $urandom, $urandom}, 1'($urandom_range(1)));
        seq[d] = seq[d] + 32'd1;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        logic exp_ir;
        logic acc;
        logic drn;
        exp_ir = (d == 0) ? (cnt[d] < 2) : (cnt[d] == 0 || out_ready[d]);
        checkOutput($sformatf("rand%0d in_ready", d), in_ready[d], exp_ir);
        checkOutput($sformatf("rand%0d out_valid", d), out_valid[d], (cnt[d] > 0));
        checkOutput($sformatf("rand%0d occupancy", d), occupancy[d], W'(cnt[d]));
        if (cnt[d] > 0) begin
          checkOutput($sformatf("rand%0d out_data", d), out_data[d], mdl[d][0]);
        end
        acc = in_valid[d] && exp_ir;
        drn = (cnt[d] > 0) && out_ready[d];
        if (drn) begin
          mdl[d][0] = mdl[d][1];
          cnt[d]--;
          beats[d]++;
        end
        if (acc && !flush[d]) begin
          mdl[d][cnt[d]] = in_data[d];
          cnt[d]++;
        end
        if (flush[d]) cnt[d] = 0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("random beats completed", (beats[0] >= BEATS && beats[1] >= BEATS), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
